// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Load/store requester sitting between the execute stage and a single-port
//   synchronous data memory (1-cycle read latency). Requests are issued to the
//   memory combinationally in the cycle they are accepted. Load data is
//   captured one cycle later into an in-order response FIFO that writeback
//   drains. Issue is credit-limited so the FIFO can never overflow.
//
// Handshakes (both request and response sides):
//   A transfer happens on a rising edge where valid && ready are both 1.
//   ready never depends on valid. A producer holding valid may change its
//   payload only after the transfer.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake from execute
//   req_rw/addr/wdata/tag      request payload (rw: 1 = store, 0 = load)
//   mem_en/rw/addr/wdata       memory port, driven from the accepted request
//   mem_rdata                  memory read data, valid the cycle after a read
//   rsp_valid/rsp_ready        response handshake to writeback
//   rsp_data/rsp_tag           head-of-FIFO load response
//   ld_count/st_count          8-bit wrapping counts of accepted loads/stores
module mem_req_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [7:0]        ld_count,
  output logic [7:0]        st_count
);

  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OCC_W  = PTR_W + 1;
  localparam int USED_W = OCC_W + 1;
  localparam logic [USED_W-1:0] DEPTH_U = USED_W'(RSP_DEPTH);

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              load_pending_q, load_pending_d;
  logic [TAG_W-1:0]  pending_tag_q, pending_tag_d;
  logic [7:0]        ld_count_q, ld_count_d;
  logic [7:0]        st_count_q, st_count_d;

  logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
  logic [TAG_W-1:0]  fifo_tag_q  [RSP_DEPTH];

  logic [USED_W-1:0] used;
  logic              accept;
  logic              ld_accept;
  logic              st_accept;
  logic              push;
  logic              pop;

  // A credit is held from load accept until its response is popped: the
  // in-flight load (load_pending) counts alongside the buffered entries.
  assign used      = {1'b0, occ_q} + USED_W'(load_pending_q);
  assign req_ready = !reset && (used < DEPTH_U);
  assign accept    = req_valid && req_ready;
  assign ld_accept = accept && !req_rw;
  assign st_accept = accept && req_rw;

  assign mem_en    = accept;
  assign mem_rw    = req_rw && accept;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  // Read data arrives the cycle after the load was issued.
  assign push      = load_pending_q;
  assign rsp_valid = !reset && (occ_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Head entry is masked so the outputs are clean zero while empty/in reset.
  assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_tag   = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;
  assign ld_count  = ld_count_q;
  assign st_count  = st_count_q;

  always_comb begin
    occ_d          = occ_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    load_pending_d = ld_accept;
    pending_tag_d  = pending_tag_q;
    ld_count_d     = ld_count_q;
    st_count_d     = st_count_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Back-to-back loads keep load_pending high and reload the tag.
    if (ld_accept) begin
      pending_tag_d = req_tag;
      ld_count_d    = ld_count_q + 8'd1;
    end
    if (st_accept) st_count_d = st_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q          <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      load_pending_q <= 1'b0;
      pending_tag_q  <= '0;
      ld_count_q     <= '0;
      st_count_q     <= '0;
    end else begin
      occ_q          <= occ_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      load_pending_q <= load_pending_d;
      pending_tag_q  <= pending_tag_d;
      ld_count_q     <= ld_count_d;
      st_count_q     <= st_count_d;
    end
  end

  // Storage needs no reset: entries are only visible once occupancy covers them.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
      fifo_tag_q[wr_ptr_q]  <= pending_tag_q;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl
//   Drives mem_req_ctrl against a behavioural memory, and checks every cycle
//   against a transaction-level reference: credits = loads accepted but not
//   yet popped, responses = a queue of (data, tag, cycle-available).
module tb_mem_req_ctrl;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int TAG_W     = 3;
  localparam int RSP_DEPTH = 4;
  localparam int EXP_W     = DATA_W + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset     = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_rw    = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag   = '0;
  logic              rsp_ready = 1'b0;
  logic              req_ready;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [7:0]        ld_count;
  logic [7:0]        st_count;

  mem_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .ld_count(ld_count), .st_count(st_count)
  );

  // ---------------- behavioural RAM (environment) ----------------
  logic [DATA_W-1:0] ram [0:65535];
  logic [DATA_W-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) ram[mem_addr] <= mem_wdata;
      else        rdata_q       <= ram[mem_addr];
    end
  end
  assign mem_rdata = rdata_q;

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [EXP_W-1:0]  exp_q[$];
  int                avail_q[$];
  int                outstanding = 0;
  logic [7:0]        m_ld = '0;
  logic [7:0]        m_st = '0;
  int                cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check just before
  // the rising edge, then advance the reference to the post-edge state.
  task automatic step(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] wd, input logic [TAG_W-1:0] t,
                      input logic rr, input logic rst, output logic acc);
    logic             exp_ready;
    logic             exp_vld;
    logic [EXP_W-1:0] head;
    @(negedge clk);
    req_valid = v; req_rw = rw; req_addr = a; req_wdata = wd; req_tag = t;
    rsp_ready = rr; reset = rst;
    #4;
    exp_ready = !rst && (outstanding < RSP_DEPTH);
    exp_vld   = !rst && (exp_q.size() > 0) && (avail_q[0] <= cyc);
    acc       = v && exp_ready;

    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    chk("mem_en",    {31'd0, mem_en},    {31'd0, acc});
    chk("mem_rw",    {31'd0, mem_rw},    {31'd0, acc && rw});
    if (acc) chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
    if (acc && rw) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_vld});
    if (exp_vld) begin
      head = exp_q[0];
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, head[EXP_W-1:TAG_W]});
      chk("rsp_tag",  {29'd0, rsp_tag},  {29'd0, head[TAG_W-1:0]});
    end
    if (rst) begin
      chk("rsp_data_rst", {16'd0, rsp_data}, 32'd0);
      chk("rsp_tag_rst",  {29'd0, rsp_tag},  32'd0);
    end
    chk("ld_count", {24'd0, ld_count}, {24'd0, m_ld});
    chk("st_count", {24'd0, st_count}, {24'd0, m_st});

    if (rst) begin
      exp_q.delete();
      avail_q.delete();
      outstanding = 0;
      m_ld = '0;
      m_st = '0;
    end else begin
      if (exp_vld && rr) begin
        void'(exp_q.pop_front());
        void'(avail_q.pop_front());
        outstanding--;
      end
      if (acc) begin
        if (rw) begin
          ref_mem[a] = wd;
          m_st++;
        end else begin
          exp_q.push_back({ref_mem[a], t});
          avail_q.push_back(cyc + 2);
          outstanding++;
          m_ld++;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr, 1'b0, acc);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                      input logic rr, output logic acc);
    step(1'b1, 1'b0, a, '0, t, rr, 1'b0, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   idx;
    int   guard;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = DATA_W'(i * 7) ^ 16'h5A5A;
      ref_mem[i] = DATA_W'(i * 7) ^ 16'h5A5A;
    end
    for (int i = 1; i <= 4; i++) begin
      ram[i]     = DATA_W'(i * 16'h1111);
      ref_mem[i] = DATA_W'(i * 16'h1111);
    end

    // Reset held with a request offered: nothing may issue.
    step(1'b1, 1'b0, 16'h0003, '0, 3'd2, 1'b1, 1'b1, acc);
    step(1'b1, 1'b1, 16'h0003, 16'h1234, 3'd2, 1'b1, 1'b1, acc);
    idle(1, 1'b1);

    // Store followed by load to the same address.
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF, '0, 1'b1, 1'b0, acc);
    load(16'h0010, 3'd5, 1'b1, acc);
    idle(3, 1'b1);

    // Back-to-back loads, writeback always ready.
    for (int i = 1; i <= 4; i++) load(ADDR_W'(i), TAG_W'(i), 1'b1, acc);
    idle(4, 1'b1);

    // Back-pressure: six loads offered with writeback stalled.
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      load(16'h0020 + ADDR_W'(idx), TAG_W'(idx), 1'b0, acc);
      if (acc) idx++;
    end
    idle(2, 1'b0);
    guard = 0;
    while (idx < 6 && guard < 40) begin
      load(16'h0020 + ADDR_W'(idx), TAG_W'(idx), 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    idle(6, 1'b1);

    // Steady stream with simultaneous push and pop.
    for (int i = 0; i < 24; i++)
      load(ADDR_W'($urandom_range(0, 63)), TAG_W'(i), 1'b1, acc);
    idle(4, 1'b1);

    // Reset while a load is in flight, then a fresh load.
    load(16'h0002, 3'd6, 1'b1, acc);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, acc);
    idle(4, 1'b1);
    load(16'h0003, 3'd7, 1'b1, acc);
    idle(4, 1'b1);

    // Randomized traffic with occasional reset and bursty back-pressure.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7),
           ($urandom_range(0, 2) == 0),
           ADDR_W'($urandom_range(0, 15)),
           DATA_W'($urandom),
           TAG_W'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 199) == 0),
           acc);
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
